// File: rtl/alu_pipe_param.sv
// Pipelined integer ALU with valid/ready on both sides, in-order completion
// and a multi-cycle restoring divider that feeds the head of the pipe.
`timescale 1ns/1ps
module alu_pipe_param #(
  parameter int WIDTH       = 8,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int SHW   = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH);
  localparam int LAST  = PIPE_STAGES - 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIVU = 4'd3;
  localparam logic [3:0] OP_REMU = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;

  // {zero, neg, carry, overflow}, always derived from the final result
  function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r,
                                          input logic c, input logic v);
    return {(r == '0), r[WIDTH-1], c, v};
  endfunction

  // One restoring step: returns {remainder, quotient/dividend shift register}.
  // rem < den always holds, so the difference fits in WIDTH bits.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                  input logic [WIDTH-1:0] quo,
                                                  input logic [WIDTH-1:0] den);
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] diff;
    sh   = {rem, quo[WIDTH-1]};
    diff = sh[WIDTH-1:0] - den;
    if (sh >= {1'b0, den}) return {diff, quo[WIDTH-2:0], 1'b1};
    else                   return {sh[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
  endfunction

  // Pipeline stage storage
  logic [PIPE_STAGES-1:0] s_valid_q;
  logic [WIDTH-1:0]       s_res_q   [PIPE_STAGES];
  logic [3:0]             s_flags_q [PIPE_STAGES];
  logic [TAG_W-1:0]       s_tag_q   [PIPE_STAGES];

  // Divider state
  logic             div_busy_q,   div_busy_d;
  logic [CNT_W-1:0] div_cnt_q,    div_cnt_d;
  logic [WIDTH-1:0] div_rem_q,    div_rem_d;
  logic [WIDTH-1:0] div_quo_q,    div_quo_d;
  logic [WIDTH-1:0] div_b_q,      div_b_d;
  logic             div_is_rem_q, div_is_rem_d;
  logic [TAG_W-1:0] div_tag_q,    div_tag_d;
  logic             div_done;

  logic             stall, accept, in_is_div;
  logic             s1_valid_d;
  logic [WIDTH-1:0] s1_res_d;
  logic [3:0]       s1_flags_d;
  logic [TAG_W-1:0] s1_tag_d;

  // Single-cycle datapath
  logic [WIDTH-1:0]        alu_res;
  logic                    alu_c, alu_v;
  logic [SHW-1:0]          shamt;
  logic [WIDTH:0]          sum_ext, diff_ext, shl_ext, shr_ext;
  logic signed [WIDTH:0]   sra_ext;
  logic [2*WIDTH-1:0]      prod;

  assign stall     = s_valid_q[LAST] & ~out_ready;
  // A waiting divide result owns the next S1 slot, so div_busy covers it too
  assign in_ready  = ~stall & ~div_busy_q;
  assign accept    = in_valid & in_ready;
  assign in_is_div = (in_op == OP_DIVU) || (in_op == OP_REMU);
  assign div_done  = div_busy_q && (div_cnt_q == '0);

  assign shamt    = in_b[SHW-1:0];
  assign sum_ext  = {1'b0, in_a} + {1'b0, in_b};
  assign diff_ext = {1'b0, in_a} - {1'b0, in_b};
  assign shl_ext  = {1'b0, in_a} << shamt;
  assign shr_ext  = {in_a, 1'b0} >> shamt;
  assign sra_ext  = $signed({in_a, 1'b0}) >>> shamt;
  assign prod     = {{WIDTH{1'b0}}, in_a} * {{WIDTH{1'b0}}, in_b};

  // Result and carry/overflow for the single-cycle opcodes
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (in_op)
      OP_ADD: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (alu_res[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff_ext[WIDTH-1:0];
        alu_c   = diff_ext[WIDTH];
        alu_v   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (alu_res[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_MUL: begin
        alu_res = prod[WIDTH-1:0];
        alu_c   = |prod[2*WIDTH-1:WIDTH];
      end
      OP_SHL: begin
        alu_res = shl_ext[WIDTH-1:0];
        alu_c   = shl_ext[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_ext[WIDTH:1];
        alu_c   = shr_ext[0];
      end
      OP_SRA: begin
        alu_res = sra_ext[WIDTH:1];
        alu_c   = sra_ext[0];
      end
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      default: alu_res = '0;
    endcase
  end

  // Divider: first step on the accept edge, WIDTH-1 more, then hold until S1 is free
  always_comb begin
    div_busy_d   = div_busy_q;
    div_cnt_d    = div_cnt_q;
    div_rem_d    = div_rem_q;
    div_quo_d    = div_quo_q;
    div_b_d      = div_b_q;
    div_is_rem_d = div_is_rem_q;
    div_tag_d    = div_tag_q;
    if (accept && in_is_div) begin
      {div_rem_d, div_quo_d} = div_step('0, in_a, in_b);
      div_b_d      = in_b;
      div_is_rem_d = (in_op == OP_REMU);
      div_tag_d    = in_tag;
      div_busy_d   = 1'b1;
      div_cnt_d    = CNT_W'(WIDTH - 1);
    end else if (div_busy_q) begin
      if (div_cnt_q != '0) begin
        {div_rem_d, div_quo_d} = div_step(div_rem_q, div_quo_q, div_b_q);
        div_cnt_d = div_cnt_q - CNT_W'(1);
      end else if (!stall) begin
        div_busy_d = 1'b0;
      end
    end
  end

  // Divider registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_busy_q   <= 1'b0;
      div_cnt_q    <= '0;
      div_rem_q    <= '0;
      div_quo_q    <= '0;
      div_b_q      <= '0;
      div_is_rem_q <= 1'b0;
      div_tag_q    <= '0;
    end else begin
      div_busy_q   <= div_busy_d;
      div_cnt_q    <= div_cnt_d;
      div_rem_q    <= div_rem_d;
      div_quo_q    <= div_quo_d;
      div_b_q      <= div_b_d;
      div_is_rem_q <= div_is_rem_d;
      div_tag_q    <= div_tag_d;
    end
  end

  // S1 entry: a finished divide has priority (in_ready is low then anyway)
  always_comb begin
    s1_valid_d = 1'b0;
    s1_res_d   = '0;
    s1_flags_d = '0;
    s1_tag_d   = '0;
    if (div_done) begin
      s1_valid_d = 1'b1;
      s1_res_d   = div_is_rem_q ? div_rem_q : div_quo_q;
      s1_flags_d = mk_flags(s1_res_d, 1'b0, div_b_q == '0);
      s1_tag_d   = div_tag_q;
    end else if (accept && !in_is_div) begin
      s1_valid_d = 1'b1;
      s1_res_d   = alu_res;
      s1_flags_d = mk_flags(alu_res, alu_c, alu_v);
      s1_tag_d   = in_tag;
    end
  end

  // Stage chain: whole pipe advances together unless the output is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid_q <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) begin
        s_res_q[i]   <= '0;
        s_flags_q[i] <= '0;
        s_tag_q[i]   <= '0;
      end
    end else if (!stall) begin
      s_valid_q[0] <= s1_valid_d;
      s_res_q[0]   <= s1_res_d;
      s_flags_q[0] <= s1_flags_d;
      s_tag_q[0]   <= s1_tag_d;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        s_valid_q[i] <= s_valid_q[i-1];
        s_res_q[i]   <= s_res_q[i-1];
        s_flags_q[i] <= s_flags_q[i-1];
        s_tag_q[i]   <= s_tag_q[i-1];
      end
    end
  end

  assign out_valid  = s_valid_q[LAST];
  assign out_result = s_res_q[LAST];
  assign out_flags  = s_flags_q[LAST];
  assign out_tag    = s_tag_q[LAST];
  assign busy       = div_busy_q | (|s_valid_q);

endmodule

// File: tb/tb_alu_pipe_param.sv
// Directed bench for alu_pipe_param at WIDTH=8, PIPE_STAGES=2, TAG_W=4.
`timescale 1ns/1ps
module tb_alu_pipe_param;

  logic       clk, rst_n;
  logic       in_valid, in_ready;
  logic [7:0] in_a, in_b;
  logic [3:0] in_op, in_tag;
  logic       out_valid, out_ready;
  logic [7:0] out_result;
  logic [3:0] out_flags, out_tag;
  logic       busy;

  int checks = 0;
  int errors = 0;

  alu_pipe_param #(.WIDTH(8), .PIPE_STAGES(2), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_tag(out_tag),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Offer one op and return 1ns after the edge that accepted it
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] tag, output bit to);
    int k = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    #1;
    while (in_ready !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
    to = (k >= 100);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for a result (out_ready high), capture it, let it be consumed
  task automatic wait_out(output logic [7:0] r, output logic [3:0] f, output logic [3:0] t,
                          output int lat, output bit to);
    int k = 0;
    while (out_valid !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
    to = (k >= 100);
    r = out_result; f = out_flags; t = out_tag; lat = k + 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy_in_rst got %b exp 0", busy); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_result !== 8'h00) begin errors++; $display("FAIL reset_result got %h exp 00", out_result); end
    checks++; if (out_flags !== 4'h0) begin errors++; $display("FAIL reset_flags got %b exp 0000", out_flags); end
    checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_tag got %h exp 0", out_tag); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_add();
    logic [7:0] r; logic [3:0] f, t; int lat; bit to1, to2;
    send(4'd0, 8'hFF, 8'h01, 4'd3, to1);
    wait_out(r, f, t, lat, to2);
    checks++; if (to1 || to2) begin errors++; $display("FAIL add_timeout got %b%b exp 00", to1, to2); end
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL add_result got %h exp 00", r); end
    checks++; if (f !== 4'b1010) begin errors++; $display("FAIL add_flags got %b exp 1010", f); end
    checks++; if (t !== 4'd3) begin errors++; $display("FAIL add_tag got %h exp 3", t); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL add_latency got %0d exp 2", lat); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_consumed got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_alu_ops();
    logic [3:0] op_t [14] = '{4'd1, 4'd1, 4'd2, 4'd7, 4'd5, 4'd5, 4'd5, 4'd6,
                              4'd8, 4'd9, 4'd10, 4'd12, 4'd2, 4'd0};
    logic [7:0] a_t  [14] = '{8'h80, 8'h01, 8'h10, 8'h90, 8'h81, 8'h81, 8'h81, 8'h81,
                              8'hF0, 8'h0F, 8'hAA, 8'h55, 8'h0F, 8'h7F};
    logic [7:0] b_t  [14] = '{8'h01, 8'h02, 8'h10, 8'h02, 8'h01, 8'h09, 8'h00, 8'h01,
                              8'h3C, 8'h80, 8'hAA, 8'h33, 8'h0F, 8'h01};
    logic [7:0] r_t  [14] = '{8'h7F, 8'hFF, 8'h00, 8'hE4, 8'h02, 8'h02, 8'h81, 8'h40,
                              8'h30, 8'h8F, 8'h00, 8'h00, 8'hE1, 8'h80};
    logic [3:0] f_t  [14] = '{4'b0001, 4'b0110, 4'b1010, 4'b0100, 4'b0010, 4'b0010, 4'b0100, 4'b0010,
                              4'b0000, 4'b0100, 4'b1000, 4'b1000, 4'b0100, 4'b0101};
    logic [7:0] r; logic [3:0] f, t; int lat; bit to1, to2;
    for (int i = 0; i < 14; i++) begin
      send(op_t[i], a_t[i], b_t[i], 4'(i), to1);
      wait_out(r, f, t, lat, to2);
      checks++; if (to1 || to2) begin errors++; $display("FAIL op%0d_timeout got %b%b exp 00", i, to1, to2); end
      checks++; if (r !== r_t[i]) begin errors++; $display("FAIL op%0d_result got %h exp %h", i, r, r_t[i]); end
      checks++; if (f !== f_t[i]) begin errors++; $display("FAIL op%0d_flags got %b exp %b", i, f, f_t[i]); end
      checks++; if (t !== 4'(i)) begin errors++; $display("FAIL op%0d_tag got %h exp %h", i, t, 4'(i)); end
    end
  endtask

  task automatic test_div();
    logic [7:0] r; logic [3:0] f, t; int lat, low, k; bit to1, to2;
    // DIVU 200/7 with in_ready and latency tracking
    send(4'd3, 8'd200, 8'd7, 4'd5, to1);
    k = 0; low = 0;
    while (out_valid !== 1'b1 && k < 100) begin
      if (in_ready === 1'b0) low++;
      @(posedge clk); #1; k++;
    end
    checks++; if (to1 || k >= 100) begin errors++; $display("FAIL divu_timeout got %b/%0d exp 0/<100", to1, k); end
    checks++; if (out_result !== 8'h1C) begin errors++; $display("FAIL divu_result got %h exp 1c", out_result); end
    checks++; if (out_flags !== 4'b0000) begin errors++; $display("FAIL divu_flags got %b exp 0000", out_flags); end
    checks++; if (out_tag !== 4'd5) begin errors++; $display("FAIL divu_tag got %h exp 5", out_tag); end
    checks++; if (k + 1 !== 10) begin errors++; $display("FAIL divu_latency got %0d exp 10", k + 1); end
    checks++; if (low !== 8) begin errors++; $display("FAIL divu_in_ready_low got %0d exp 8", low); end
    @(posedge clk); #1;

    send(4'd4, 8'd200, 8'd7, 4'd6, to1);
    wait_out(r, f, t, lat, to2);
    checks++; if (to1 || to2) begin errors++; $display("FAIL remu_timeout got %b%b exp 00", to1, to2); end
    checks++; if (r !== 8'h04) begin errors++; $display("FAIL remu_result got %h exp 04", r); end
    checks++; if (f !== 4'b0000) begin errors++; $display("FAIL remu_flags got %b exp 0000", f); end
    checks++; if (lat !== 10) begin errors++; $display("FAIL remu_latency got %0d exp 10", lat); end

    send(4'd3, 8'd5, 8'd0, 4'd7, to1);
    wait_out(r, f, t, lat, to2);
    checks++; if (to1 || to2) begin errors++; $display("FAIL div0_timeout got %b%b exp 00", to1, to2); end
    checks++; if (r !== 8'hFF) begin errors++; $display("FAIL div0_result got %h exp ff", r); end
    checks++; if (f !== 4'b0101) begin errors++; $display("FAIL div0_flags got %b exp 0101", f); end
    checks++; if (lat !== 10) begin errors++; $display("FAIL div0_latency got %0d exp 10", lat); end

    send(4'd4, 8'd5, 8'd0, 4'd8, to1);
    wait_out(r, f, t, lat, to2);
    checks++; if (to1 || to2) begin errors++; $display("FAIL rem0_timeout got %b%b exp 00", to1, to2); end
    checks++; if (r !== 8'h05) begin errors++; $display("FAIL rem0_result got %h exp 05", r); end
    checks++; if (f !== 4'b0001) begin errors++; $display("FAIL rem0_flags got %b exp 0001", f); end
    checks++; if (t !== 4'd8) begin errors++; $display("FAIL rem0_tag got %h exp 8", t); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a_t [4] = '{8'h01, 8'h11, 8'h7F, 8'hF0};
    logic [7:0] r_t [4] = '{8'h21, 8'h31, 8'h9F, 8'h10};
    logic [3:0] f_t [4] = '{4'b0000, 4'b0000, 4'b0101, 4'b0010};
    logic [7:0] r_got [4];
    logic [3:0] f_got [4];
    logic [3:0] t_got [4];
    int sent = 0, rcvd = 0, stall_seen = 0;
    for (int c = 0; c < 40 && rcvd < 4; c++) begin
      @(posedge clk); #1;
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (sent < 4);
      if (sent < 4) begin
        in_op = 4'd0; in_a = a_t[sent]; in_b = 8'h20; in_tag = sent[3:0];
      end
      #1;
      checks++;
      if (in_ready !== ~(out_valid & ~out_ready)) begin
        errors++; $display("FAIL b2b_in_ready c%0d got %b exp %b", c, in_ready, ~(out_valid & ~out_ready));
      end
      if (in_valid && !in_ready) stall_seen++;
      if (out_valid && out_ready) begin
        r_got[rcvd] = out_result; f_got[rcvd] = out_flags; t_got[rcvd] = out_tag; rcvd++;
      end
      if (in_valid && in_ready) sent++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (rcvd !== 4) begin errors++; $display("FAIL b2b_count got %0d exp 4", rcvd); end
    checks++; if (stall_seen == 0) begin errors++; $display("FAIL b2b_stall_seen got 0 exp >0"); end
    for (int i = 0; i < 4 && i < rcvd; i++) begin
      checks++; if (r_got[i] !== r_t[i]) begin errors++; $display("FAIL b2b_result%0d got %h exp %h", i, r_got[i], r_t[i]); end
      checks++; if (f_got[i] !== f_t[i]) begin errors++; $display("FAIL b2b_flags%0d got %b exp %b", i, f_got[i], f_t[i]); end
      checks++; if (t_got[i] !== 4'(i)) begin errors++; $display("FAIL b2b_tag%0d got %h exp %h", i, t_got[i], 4'(i)); end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid_div();
    logic [7:0] r; logic [3:0] f, t; int lat, seen; bit to1, to2;
    send(4'd3, 8'd200, 8'd7, 4'd9, to1);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstdiv_busy_before got %b exp 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstdiv_busy_in_rst got %b exp 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstdiv_valid_in_rst got %b exp 0", out_valid); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstdiv_ghost_output got %0d exp 0", seen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstdiv_busy_after got %b exp 0", busy); end
    send(4'd0, 8'd2, 8'd3, 4'd6, to1);
    wait_out(r, f, t, lat, to2);
    checks++; if (to1 || to2) begin errors++; $display("FAIL rstdiv_add_timeout got %b%b exp 00", to1, to2); end
    checks++; if (r !== 8'h05) begin errors++; $display("FAIL rstdiv_add_result got %h exp 05", r); end
    checks++; if (f !== 4'b0000) begin errors++; $display("FAIL rstdiv_add_flags got %b exp 0000", f); end
    checks++; if (t !== 4'd6) begin errors++; $display("FAIL rstdiv_add_tag got %h exp 6", t); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL rstdiv_add_latency got %0d exp 2", lat); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_div();
    test_back_to_back();
    test_reset_mid_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
